// File: rtl/chunked_ripple_adder.sv
// rtl/chunked_ripple_adder.sv - multi-cycle ripple-carry adder, CHUNK bits per clock, valid/ready on both sides
module chunked_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             CIN,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             OVF
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;
    logic             c_msb;
    logic             accept;

    // A new operand pair may enter while idle, or while the held result is drained this cycle.
    assign I_READY = (state == IDLE) || ((state == DONE) && O_READY);
    assign O_VALID = (state == DONE);
    assign accept  = I_VALID && I_READY;

    // Select the operand slice for the chunk currently being added.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int j = 0; j < NCH; j++) begin
            if (idx == IDX_W'(j)) begin
                a_chunk = a_reg[j*CHUNK +: CHUNK];
                b_chunk = b_reg[j*CHUNK +: CHUNK];
            end
        end
    end

    // One short carry chain per clock; the carry into the top bit of the slice
    // is recovered from the sum bit so the last chunk yields the signed overflow.
    assign {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    assign c_msb            = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];

    // Control FSM and datapath registers; the result registers only move during BUSY.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            O     <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            a_reg <= I0;
            b_reg <= I1;
            carry <= CIN;
            idx   <= '0;
            state <= BUSY;
        end else begin
            case (state)
                BUSY: begin
                    for (int j = 0; j < NCH; j++) begin
                        if (idx == IDX_W'(j)) begin
                            O[j*CHUNK +: CHUNK] <= s_chunk;
                        end
                    end
                    carry <= c_out;
                    if (idx == LAST_IDX) begin
                        COUT  <= c_out;
                        OVF   <= c_msb ^ c_out;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (O_READY) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// tb/tb_chunked_ripple_adder.sv - self-checking bench for chunked_ripple_adder
module tb_chunked_ripple_adder;

    localparam int NRAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8-bit, 2-bit chunk instance for directed tests
    logic       rst8, v8, ir8, cin8, ovld8, ordy8, co8, of8;
    logic [7:0] a8, b8, o8;

    chunked_ripple_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .CLK(clk), .RESET(rst8), .I_VALID(v8), .I_READY(ir8),
        .I0(a8), .I1(b8), .CIN(cin8), .O_VALID(ovld8), .O_READY(ordy8),
        .O(o8), .COUT(co8), .OVF(of8)
    );

    // 16-bit instances with CHUNK = 1, 4, 16 for random tests
    logic        rst16;
    logic        iv16 [3];
    logic        ir16 [3];
    logic        cin16 [3];
    logic        ovl16 [3];
    logic        ordy16 [3];
    logic        co16 [3];
    logic        of16 [3];
    logic [15:0] a16 [3];
    logic [15:0] b16 [3];
    logic [15:0] o16 [3];

    chunked_ripple_adder #(.WIDTH(16), .CHUNK(1)) u_dut16_c1 (
        .CLK(clk), .RESET(rst16), .I_VALID(iv16[0]), .I_READY(ir16[0]),
        .I0(a16[0]), .I1(b16[0]), .CIN(cin16[0]), .O_VALID(ovl16[0]), .O_READY(ordy16[0]),
        .O(o16[0]), .COUT(co16[0]), .OVF(of16[0])
    );
    chunked_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_dut16_c4 (
        .CLK(clk), .RESET(rst16), .I_VALID(iv16[1]), .I_READY(ir16[1]),
        .I0(a16[1]), .I1(b16[1]), .CIN(cin16[1]), .O_VALID(ovl16[1]), .O_READY(ordy16[1]),
        .O(o16[1]), .COUT(co16[1]), .OVF(of16[1])
    );
    chunked_ripple_adder #(.WIDTH(16), .CHUNK(16)) u_dut16_c16 (
        .CLK(clk), .RESET(rst16), .I_VALID(iv16[2]), .I_READY(ir16[2]),
        .I0(a16[2]), .I1(b16[2]), .CIN(cin16[2]), .O_VALID(ovl16[2]), .O_READY(ordy16[2]),
        .O(o16[2]), .COUT(co16[2]), .OVF(of16[2])
    );

    // Reference: whole-word arithmetic, returns {ovf, cout, sum}
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s;
        logic        ovf;
        s   = {1'b0, a} + {1'b0, b} + {16'd0, c};
        ovf = (a[15] == b[15]) && (s[15] != a[15]);
        return {ovf, s[16], s[15:0]};
    endfunction

    // Drive one add on the 8-bit instance, wait for the result, then retire it
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] o, output logic co, output logic of, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        ordy8 = 1'b0;
        a8 = a; b8 = b; cin8 = c; v8 = 1'b1;
        #1;
        while (!ir8 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        v8  = 1'b0;
        lat = 0;
        while (!ovld8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        o  = o8;
        co = co8;
        of = of8;
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst16 = 1'b1;
        v8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv16[k] = 1'b0; ordy16[k] = 1'b0; a16[k] = '0; b16[k] = '0; cin16[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ovld8, co8, of8, ir8} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ctrl8: got {ovalid,cout,ovf,iready}=%b required 0001", {ovld8, co8, of8, ir8});
        end
        n_checks++;
        if (o8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_o8: got %h required 00", o8);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ovl16[k] !== 1'b0 || ir16[k] !== 1'b1 || o16[k] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset16_%0d: got ovalid=%b iready=%b o=%h required 0 1 0000", k, ovl16[k], ir16[k], o16[k]);
            end
        end
        @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        @(negedge clk);
        ordy8 = 1'b0;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; v8 = 1'b1;
        #1;
        n_checks++;
        if (ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_ready_idle: got iready=%b required 1", ir8);
        end
        @(negedge clk);
        v8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ovld8 !== 1'b0 || ir8 !== 1'b0) begin
                n_fail++;
                $display("FAIL lat_busy_%0d: got ovalid=%b iready=%b required 0 0", k, ovld8, ir8);
            end
            @(negedge clk);
        end
        n_checks++;
        if (ovld8 !== 1'b1 || o8 !== 8'h00 || co8 !== 1'b1 || of8 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_result: got ovalid=%b o=%h cout=%b ovf=%b required 1 00 1 0", ovld8, o8, co8, of8);
        end
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        n_checks++;
        if (ovld8 !== 1'b0 || ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_retire: got ovalid=%b iready=%b required 0 1", ovld8, ir8);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [7:0] eo [3];
        logic       eco [3];
        logic       eof [3];
        logic [7:0] o;
        logic       co, of;
        int         lat;
        va = '{8'h7F, 8'h80, 8'h00};
        vb = '{8'h01, 8'h80, 8'h00};
        vc = '{1'b0, 1'b0, 1'b1};
        eo = '{8'h80, 8'h00, 8'h01};
        eco = '{1'b0, 1'b1, 1'b0};
        eof = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], vc[i], o, co, of, lat);
            n_checks++;
            if (o !== eo[i] || co !== eco[i] || of !== eof[i] || lat != 4) begin
                n_fail++;
                $display("FAIL ovf_vec%0d: got o=%h cout=%b ovf=%b lat=%0d required %h %b %b 4",
                         i, o, co, of, lat, eo[i], eco[i], eof[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        ordy8 = 1'b0;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        guard = 0;
        while (!ovld8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a8 = 8'h11; b8 = 8'h22; v8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (ovld8 !== 1'b1 || o8 !== 8'h80 || co8 !== 1'b0 || of8 !== 1'b1 || ir8 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ovalid=%b o=%h cout=%b ovf=%b iready=%b required 1 80 0 1 0",
                         k, ovld8, o8, co8, of8, ir8);
            end
            @(negedge clk);
        end
        v8 = 1'b0;
        ordy8 = 1'b1;
        #1;
        n_checks++;
        if (ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_drain: got iready=%b required 1", ir8);
        end
        @(negedge clk);
        ordy8 = 1'b0;
        n_checks++;
        if (ovld8 !== 1'b0 || ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_retired: got ovalid=%b iready=%b required 0 1", ovld8, ir8);
        end
    endtask

    task automatic test_back_to_back();
        int         cyc, seen, t0, t1;
        logic [7:0] r0, r1;
        logic       c0, c1, f1, rdy0;
        cyc = 0; seen = 0; t0 = 0; t1 = 0;
        r0 = '0; r1 = '0; c0 = 1'b0; c1 = 1'b0; f1 = 1'b0; rdy0 = 1'b0;
        @(negedge clk);
        ordy8 = 1'b1;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; v8 = 1'b1;
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
        while (seen < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (seen == 1) v8 = 1'b0;
            if (ovld8) begin
                if (seen == 0) begin
                    r0 = o8; c0 = co8; t0 = cyc; rdy0 = ir8;
                end else begin
                    r1 = o8; c1 = co8; f1 = of8; t1 = cyc;
                end
                seen++;
            end
        end
        v8 = 1'b0;
        n_checks++;
        if (seen != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results required 2", seen);
        end
        n_checks++;
        if (r0 !== 8'h46 || c0 !== 1'b0 || rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got o=%h cout=%b iready=%b required 46 0 1", r0, c0, rdy0);
        end
        n_checks++;
        if (r1 !== 8'h00 || c1 !== 1'b1 || f1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got o=%h cout=%b ovf=%b required 00 1 0", r1, c1, f1);
        end
        n_checks++;
        if (t1 - t0 != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles required 5", t1 - t0);
        end
        @(negedge clk);
        ordy8 = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [7:0] o;
        logic       co, of;
        int         lat;
        @(negedge clk);
        ordy8 = 1'b1;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ovld8 !== 1'b0 || o8 !== 8'h00 || ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_state: got ovalid=%b o=%h iready=%b required 0 00 1", ovld8, o8, ir8);
        end
        rst8 = 1'b0;
        run8(8'h03, 8'h04, 1'b0, o, co, of, lat);
        n_checks++;
        if (o !== 8'h07 || co !== 1'b0 || of !== 1'b0 || lat != 4) begin
            n_fail++;
            $display("FAIL midrst_add: got o=%h cout=%b ovf=%b lat=%0d required 07 0 0 4", o, co, of, lat);
        end
    endtask

    task automatic run_rand(input int k);
        logic [17:0] q[$];
        logic [17:0] expv, got;
        int          sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0;
        while ((sent < NRAND || recv < NRAND) && cyc < 45000) begin
            @(negedge clk);
            cyc++;
            ordy16[k] = ($urandom_range(0, 3) != 0);
            if (sent < NRAND && $urandom_range(0, 9) < 6) begin
                iv16[k]  = 1'b1;
                a16[k]   = 16'($urandom);
                b16[k]   = 16'($urandom);
                cin16[k] = 1'($urandom);
            end else begin
                iv16[k] = 1'b0;
            end
            #1;
            if (ovl16[k] && ordy16[k]) begin
                got = {of16[k], co16[k], o16[k]};
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_unexpected: got result %h with nothing outstanding", k, got);
                end else begin
                    expv = q.pop_front();
                    if (got !== expv) begin
                        n_fail++;
                        $display("FAIL rand%0d_result %0d: got {ovf,cout,o}=%h required %h", k, recv, got, expv);
                    end
                end
                recv++;
            end
            if (iv16[k] && ir16[k]) begin
                q.push_back(ref16(a16[k], b16[k], cin16[k]));
                sent++;
            end
        end
        iv16[k] = 1'b0;
        ordy16[k] = 1'b0;
        n_checks++;
        if (recv != NRAND) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d results required %0d", k, recv, NRAND);
        end
    endtask

    task automatic test_random();
        fork
            run_rand(0);
            run_rand(1);
            run_rand(2);
        join
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
